// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared state encodings and 50 MHz default timing for key_event_decoder
package key_evt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    localparam int LONG_CNT_DEF   = 50_000_000;
    localparam int DCLICK_CNT_DEF = 15_000_000;
    localparam int REPEAT_CNT_DEF = 10_000_000;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - turns debounced key flags into short/double/long/repeat pulses
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter int LONG_CNT   = LONG_CNT_DEF,
    parameter int DCLICK_CNT = DCLICK_CNT_DEF,
    parameter int REPEAT_CNT = REPEAT_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic evt_short,
    output logic evt_double,
    output logic evt_long,
    output logic evt_repeat,
    output logic key_held
);

    localparam int MAX_CNT = (LONG_CNT > DCLICK_CNT)
                           ? ((LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT)
                           : ((DCLICK_CNT > REPEAT_CNT) ? DCLICK_CNT : REPEAT_CNT);

    if (LONG_CNT < 2 || DCLICK_CNT < 2 || REPEAT_CNT < 2) begin : g_bad_count
        $error("key_event_decoder: LONG_CNT, DCLICK_CNT and REPEAT_CNT must be >= 2");
    end
    if (CNT_W < $clog2(MAX_CNT)) begin : g_bad_width
        $error("key_event_decoder: CNT_W too narrow for the largest count");
    end

    localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_TERM = CNT_W'(DCLICK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CNT - 1);

    logic w_press;
    logic w_release;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    assign w_press   = key_flag & ~key_value;
    assign w_release = key_flag &  key_value;

    // Key flags are checked before counter terminals so a flag always wins a same-cycle collision.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            evt_short  <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            evt_repeat <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            evt_short  <= 1'b0;
            evt_double <= 1'b0;
            evt_long   <= 1'b0;
            evt_repeat <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_press) begin
                        r_state  <= ST_PRESS1;
                        r_cnt    <= '0;
                        key_held <= 1'b1;
                    end
                end
                ST_PRESS1: begin
                    if (w_release) begin
                        r_state  <= ST_WAIT2;
                        r_cnt    <= '0;
                        key_held <= 1'b0;
                    end else if (r_cnt == LONG_TERM) begin
                        r_state  <= ST_LONG;
                        r_cnt    <= '0;
                        evt_long <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT2: begin
                    if (w_press) begin
                        r_state  <= ST_PRESS2;
                        r_cnt    <= '0;
                        key_held <= 1'b1;
                    end else if (r_cnt == DCLICK_TERM) begin
                        r_state   <= ST_IDLE;
                        r_cnt     <= '0;
                        evt_short <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PRESS2: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        evt_double <= 1'b1;
                        key_held   <= 1'b0;
                    end
                end
                ST_LONG: begin
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= '0;
                        key_held <= 1'b0;
                    end else if (r_cnt == REPEAT_TERM) begin
                        r_cnt      <= '0;
                        evt_repeat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

endmodule
